// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data access block.
// Holds the MemCtrl op encodings, the bus data_size codes, the access FSM
// state constants and small op-classification helpers.
package mem_access_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'b0000,
    OP_LB   = 4'b0001,
    OP_LBU  = 4'b0010,
    OP_LH   = 4'b0011,
    OP_LHU  = 4'b0100,
    OP_LW   = 4'b0101,
    OP_SB   = 4'b0110,
    OP_SH   = 4'b0111,
    OP_SW   = 4'b1000
  } mem_op_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
      OP_LW, OP_SW:         return SIZE_WORD;
      default:              return SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// SRAM-like data bus between the MEM stage (master) and memory (slave).
//   data_req/data_wr/data_size/data_addr/data_wdata : master -> slave
//   data_addr_ok/data_data_ok/data_rdata            : slave -> master
interface mem_access_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// load_align: combinational lane select and extension of a raw read word.
//   op     : MemCtrl op code
//   offset : AddrM[1:0]
//   rdata  : raw 32-bit bus read word
//   ext    : aligned, sign/zero-extended load result
module load_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   ext = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  ext = {24'h000000, byte_lane};
      OP_LH:   ext = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  ext = {16'h0000, half_lane};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store sequencer on an SRAM-like data bus.
//   clock, reset       : pipeline clock, synchronous active-high reset
//   MemCtrlM           : access op from the EX/MEM register
//   AddrM, WriteDataM  : byte address and right-aligned store data
//   flush              : cancel an access that has not been accepted yet
//   bus (master)       : SRAM-like data bus
//   ReadDataM          : registered, aligned and extended load result
//   mem_stall          : holds IF..MEM while an access is in flight
//   AdELM, AdESM       : combinational load/store address errors
//
// state  | meaning
// S_IDLE | no access outstanding; request issued directly from here
// S_REQ  | request held until the address is accepted
// S_WAIT | address accepted, waiting for data_ok (not abortable)
// S_DONE | result valid, stall released for one cycle to avoid re-issue
module mem_access
  import mem_access_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         MemCtrlM,
  input  logic [31:0]        AddrM,
  input  logic [31:0]        WriteDataM,
  input  logic               flush,
  mem_access_if.master       bus,
  output logic [31:0]        ReadDataM,
  output logic               mem_stall,
  output logic               AdELM,
  output logic               AdESM
);

  state_e      state_q, state_d;
  logic [31:0] read_data_q, read_data_d;

  logic        is_load, is_store, misaligned, access;
  logic [1:0]  size;
  logic [31:0] load_word;

  always_comb begin
    is_load  = op_is_load(MemCtrlM);
    is_store = op_is_store(MemCtrlM);
    size     = op_size(MemCtrlM);
    case (size)
      SIZE_HALF: misaligned = AddrM[0];
      SIZE_WORD: misaligned = (AddrM[1:0] != 2'b00);
      default:   misaligned = 1'b0;
    endcase
    AdELM  = is_load  & misaligned;
    AdESM  = is_store & misaligned;
    access = (is_load | is_store) & ~misaligned;
  end

  load_align u_load_align (
    .op     (MemCtrlM),
    .offset (AddrM[1:0]),
    .rdata  (bus.data_rdata),
    .ext    (load_word)
  );

  always_comb begin
    state_d      = state_q;
    read_data_d  = read_data_q;
    bus.data_req = 1'b0;
    mem_stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.data_req = access & ~flush;
        mem_stall    = access & ~flush;
        if (bus.data_req) state_d = bus.data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        bus.data_req = 1'b1;
        mem_stall    = access & ~flush;
        // An accepted address must still be followed by its data_ok,
        // so acceptance wins over a same-cycle flush.
        if (bus.data_addr_ok) state_d = S_WAIT;
        else if (flush)       state_d = S_IDLE;
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (bus.data_data_ok) begin
          state_d     = S_DONE;
          read_data_d = load_word;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Synchronous reset must still leave the bus and stall quiet this cycle.
    if (reset) begin
      bus.data_req = 1'b0;
      mem_stall    = 1'b0;
    end
  end

  always_comb begin
    bus.data_wr   = is_store;
    bus.data_size = size;
    bus.data_addr = AddrM;
    case (MemCtrlM)
      OP_SB:   bus.data_wdata = {4{WriteDataM[7:0]}};
      OP_SH:   bus.data_wdata = {2{WriteDataM[15:0]}};
      default: bus.data_wdata = WriteDataM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      read_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
    end
  end

  assign ReadDataM = read_data_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Reset and clock SHALL be: reset reset, synchronous, active-high; clock clock.
REQ-002 clock  in  1  pipeline clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 MemCtrlM  in  4  access op from EX/MEM register: NONE 0000, LB 0001, LBU 0010, LH 0011, LHU 0100, LW 0101, SB 0110, SH 0111, SW 1000; other codes are treated as NONE.
REQ-005 AddrM  in  32  byte address (ALU result).
REQ-006 WriteDataM  in  32  store data, right-aligned.
REQ-007 flush  in  1  cancel current access (exception/eret from later logic).
REQ-008 data_req, data_wr  out  1 each  request strobe and write flag of the SRAM-like data bus.
REQ-009 data_size  out  2  0 = byte, 1 = half, 2 = word.
REQ-010 data_addr, data_wdata  out  32 each  bus address and bus write data.
REQ-011 data_addr_ok, data_data_ok  in  1 each  address accepted; data returned or write complete.
REQ-012 data_rdata  in  32  raw read word.
REQ-013 ReadDataM  out  32  aligned, extended load result.
REQ-014 mem_stall  out  1  freeze IF..MEM while high.
REQ-015 AdELM, AdESM  out  1 each  load/store address error.

Function
REQ-016 access = MemCtrlM not NONE and no address error; stores are SB/SH/SW; loads are the rest.
REQ-017 Address error SHALL be raised combinationally for: halfword op with AddrM[0]=1, or word op with AddrM[1:0]!=0. AdELM covers loads, AdESM covers stores. No bus request and no stall on error.
REQ-018 FSM states: IDLE, REQ, WAIT, DONE.
REQ-019 IDLE: data_req = access & !flush. With addr_ok go to WAIT, otherwise go to REQ.
REQ-020 REQ: data_req = 1, held with stable address/size/data until addr_ok, then go to WAIT. flush before addr_ok SHALL return to IDLE with no transaction issued.
REQ-021 WAIT: data_req = 0. On data_ok go to DONE and register ReadDataM. flush in WAIT SHALL NOT abort: the pending data_ok is consumed and ReadDataM is still updated.
REQ-022 DONE: data_req = 0, mem_stall = 0, unconditionally go to IDLE next cycle. This prevents re-issue while the pipeline advances.
REQ-023 mem_stall = access & (state != DONE) & !flush. mem_stall SHALL also be 1 in WAIT regardless of flush.
REQ-024 data_wr = store. data_size from op. data_addr = AddrM. data_wdata = SB {4{WriteDataM[7:0]}}, SH {2{WriteDataM[15:0]}}, SW WriteDataM.
REQ-025 Load extraction uses AddrM[1:0]: byte lane = rdata[8*off+7:8*off]; half lane = rdata[16*off[1]+15:16*off[1]]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-026 Minimum access latency SHALL be 2 cycles (IDLE with addr_ok, then WAIT with data_ok in the next cycle), so stall is high for 2 cycles. Extra addr_ok/data_ok delays SHALL add cycles 1:1.
REQ-027 data_ok when not in WAIT SHALL be ignored.

Reset
REQ-028 On reset: state IDLE, ReadDataM 0x00000000, internal registers cleared. data_req 0 in the reset cycle. Reset overrides any in-flight transaction.
REQ-029 All outputs SHALL be defined in the reset cycle: AdELM/AdESM follow their inputs combinationally, mem_stall 0.

Structure
REQ-030 The MemCtrl encodings, data_size codes and FSM state constants SHALL live in the shared defines header beside the existing width macros.
REQ-031 One sub-module, load_align: purely combinational, inputs op, offset, rdata, output extended word.
REQ-032 Implementation size: 150-250 lines. A single state register; ReadDataM is the only datapath flop.

Verification
REQ-033 LW AddrM 0x80001000, addr_ok and data_ok immediate, rdata 0x12345678 -> stall high 2 cycles, ReadDataM 0x12345678 in DONE.
REQ-034 LB AddrM 0x80001003, rdata 0x80FFFFFF -> ReadDataM 0xFFFFFF80. Same with LBU -> 0x00000080.
REQ-035 SH AddrM 0x80002002, WriteDataM 0xAAAA1234 -> data_wr 1, size 1, wdata 0x12341234. addr_ok delayed 3 cycles: req held stable, stall high 5 cycles.
REQ-036 LW AddrM 0x80000002 -> AdELM 1, data_req 0, mem_stall 0. SW AddrM 0x80000001 -> AdESM 1.
REQ-037 flush in REQ before addr_ok -> IDLE next cycle, no request. flush in WAIT -> stays until data_ok, then DONE.
REQ-038 reset asserted in WAIT -> IDLE, ReadDataM 0, data_req 0. A later stray data_ok is ignored.
